sixty_four_bit_seq_subtractor: RTL



---
 rtl/sixty_four_bit_seq_subtractor.sv | 111 +++++++++++
 1 files changed

// File: rtl/sixty_four_bit_seq_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin, computed CHUNK_W bits per clock as
// A + ~B + ~Bin through a registered carry chain, with valid/ready on both sides.
// WIDTH must be a multiple of CHUNK_W.
module sixty_four_bit_seq_subtractor #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Borrow_Out,
  output logic             Ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, nb_q, d_q;
  logic             carry_q, borrow_q, ovf_q;
  logic [IdxW-1:0]  idx_q;

  logic [31:0]      chunk_base;
  logic [CHUNK_W:0] chunk_sum;
  logic             accept, last_chunk, fin_ovf;

  assign accept     = (state_q == StIdle) && in_valid;
  assign last_chunk = (state_q == StRun) && (idx_q == LastIdx);

  // Chunk adder: current slice of A plus inverted B plus the running carry.
  always_comb begin
    chunk_base = 32'(idx_q) * CHUNK_W;
    chunk_sum  = {1'b0, a_q[chunk_base +: CHUNK_W]} + {1'b0, nb_q[chunk_base +: CHUNK_W]}
               + {{CHUNK_W{1'b0}}, carry_q};
    // nb_q holds ~B, so equal MSBs mean A and B had opposite signs.
    fin_ovf    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (chunk_sum[CHUNK_W-1] != a_q[WIDTH-1]);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, per-chunk result write and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      nb_q     <= '0;
      d_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else if (accept) begin
      a_q     <= A;
      nb_q    <= ~B;
      carry_q <= ~Bin;
      idx_q   <= '0;
    end else if (state_q == StRun) begin
      d_q[chunk_base +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
      carry_q                    <= chunk_sum[CHUNK_W];
      idx_q                      <= idx_q + 1'b1;
      if (last_chunk) begin
        // No final carry out of A + ~B + ~Bin means the true result went negative.
        borrow_q <= ~chunk_sum[CHUNK_W];
        ovf_q    <= fin_ovf;
        idx_q    <= '0;
      end
    end
  end

  assign D          = d_q;
  assign Borrow_Out = borrow_q;
  assign Ovf        = ovf_q;

endmodule
